// File: rtl/lp_filter_cascade.sv
// rtl/lp_filter_cascade.sv - runtime-configurable cascade of power-of-two IIR low-pass stages
module lp_filter_cascade #(
    parameter int R     = 14,
    parameter int S     = 49,
    parameter int ORDER = 2,
    parameter int OFF   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          tau,
    input  logic [2:0]          order,
    input  logic                hold,
    input  logic                load,
    input  logic                clr_ovf,
    input  logic signed [R-1:0] in,
    output logic signed [R-1:0] out,
    output logic                settled,
    output logic                ovf
);
    localparam int TAU_MAX = S - R - OFF - 1;
    // Clamp target for the shift; a negative TAU_MAX means the filtered path is never valid.
    localparam int TAU_LIM = (TAU_MAX < 0) ? 0 : TAU_MAX;
    localparam logic [5:0] TAU_LIM_V = 6'(TAU_LIM);
    localparam logic [2:0] ORDER_V   = 3'(ORDER);
    localparam logic [6:0] OFF_V     = 7'(OFF);
    localparam logic signed [S-1:0] ACC_MAX = {1'b0, {(S-1){1'b1}}};
    localparam logic signed [S-1:0] ACC_MIN = {1'b1, {(S-1){1'b0}}};

    logic signed [S-1:0] acc_q [ORDER];
    logic signed [S-1:0] acc_d [ORDER];
    logic signed [R-1:0] out_q, out_d;
    logic [S-1:0]        cnt_q, cnt_d;
    logic [5:0]          tau_q;
    logic [2:0]          order_q;
    logic                ovf_q, ovf_d;
    logic                settled_q, settled_d;

    logic                tau_valid;
    logic [5:0]          tau_c;
    logic [6:0]          k;
    logic [2:0]          order_eff;
    logic signed [R-1:0] y [ORDER];
    logic signed [S-1:0] shr;
    logic signed [S-1:0] pre;
    logic signed [R-1:0] x;
    logic [S:0]          sum;
    logic [S-1:0]        thr;
    logic                sat_any;

    // Decode validity, effective shift (clamped so accumulators keep running) and order.
    always_comb begin
        tau_valid = (TAU_MAX >= 0) && (tau <= TAU_LIM_V);
        tau_c     = (tau > TAU_LIM_V) ? TAU_LIM_V : tau;
        k         = OFF_V + {1'b0, tau_c};
        order_eff = (order > ORDER_V) ? ORDER_V : order;
    end

    // Stage outputs: arithmetic right shift of each accumulator, low R bits kept.
    always_comb begin
        shr = '0;
        for (int i = 0; i < ORDER; i++) begin
            shr  = acc_q[i] >>> k;
            y[i] = shr[R-1:0];
        end
    end

    // Accumulator next state: preload, hold, or saturating leaky integration per stage.
    always_comb begin
        pre     = {{(S-R){in[R-1]}}, in} <<< k;
        sat_any = 1'b0;
        x       = in;
        sum     = '0;
        for (int i = 0; i < ORDER; i++) begin
            sum = {acc_q[i][S-1], acc_q[i]}
                + {{(S+1-R){x[R-1]}}, x}
                - {{(S+1-R){y[i][R-1]}}, y[i]};
            acc_d[i] = acc_q[i];
            if (load) begin
                acc_d[i] = pre;
            end else if (!hold && (3'(i) < order_eff)) begin
                case (sum[S:S-1])
                    2'b01: begin
                        acc_d[i] = ACC_MAX;
                        sat_any  = 1'b1;
                    end
                    2'b10: begin
                        acc_d[i] = ACC_MIN;
                        sat_any  = 1'b1;
                    end
                    default: acc_d[i] = sum[S-1:0];
                endcase
            end
            x = y[i];
        end
    end

    // Output select, settle counter, settled compare and sticky overflow.
    always_comb begin
        out_d = in;
        if (tau_valid && (order_eff != 3'd0)) begin
            for (int i = 0; i < ORDER; i++) begin
                if (3'(i + 1) == order_eff) out_d = y[i];
            end
        end
        cnt_d = cnt_q;
        if (load || (tau != tau_q) || (order != order_q)) begin
            cnt_d = '0;
        end else if (!hold && (cnt_q != '1)) begin
            cnt_d = cnt_q + S'(1);
        end
        thr       = {{(S-3){1'b0}}, order_eff} << (k + 7'd3);
        settled_d = (!tau_valid || (order_eff == 3'd0)) ? 1'b1 : (cnt_d >= thr);
        ovf_d     = sat_any | (ovf_q & ~clr_ovf);
    end

    // State registers; configuration copies track the ports even during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ORDER; i++) acc_q[i] <= '0;
            out_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            for (int i = 0; i < ORDER; i++) acc_q[i] <= acc_d[i];
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            settled_q <= settled_d;
        end
        tau_q   <= tau;
        order_q <= order;
    end

    assign out     = out_q;
    assign settled = settled_q;
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_lp_filter_cascade.sv
// tb/tb_lp_filter_cascade.sv - directed self-checking bench for lp_filter_cascade
module tb_lp_filter_cascade;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, hold, load, clr_ovf;
    logic [5:0]         tau;
    logic [2:0]         order;
    logic signed [13:0] in, out;
    logic               settled, ovf;

    logic               hold2, load2, clr2;
    logic [5:0]         tau2;
    logic [2:0]         order2;
    logic signed [13:0] in2, out2;
    logic               settled2, ovf2;

    int total = 0;
    int bad   = 0;

    longint             m_acc [2];
    logic signed [13:0] m_out;
    int                 o1 [0:200];

    lp_filter_cascade #(.R(14), .S(49), .ORDER(2), .OFF(6)) dut (
        .clk(clk), .rst(rst), .tau(tau), .order(order), .hold(hold), .load(load),
        .clr_ovf(clr_ovf), .in(in), .out(out), .settled(settled), .ovf(ovf)
    );

    // Narrow accumulator instance so full-scale input can saturate.
    lp_filter_cascade #(.R(14), .S(19), .ORDER(1), .OFF(6)) dut_sat (
        .clk(clk), .rst(rst), .tau(tau2), .order(order2), .hold(hold2), .load(load2),
        .clr_ovf(clr2), .in(in2), .out(out2), .settled(settled2), .ovf(ovf2)
    );

    function automatic longint m_y(longint a, int kk);
        longint t;
        logic signed [13:0] v;
        t = a >>> kk;
        v = t[13:0];
        return longint'(v);
    endfunction

    task automatic model_step();
        int kk, oe;
        longint y0, y1, n0, n1;
        kk = 6 + ((tau > 6'd28) ? 28 : int'(tau));
        oe = (order > 3'd2) ? 2 : int'(order);
        y0 = m_y(m_acc[0], kk);
        y1 = m_y(m_acc[1], kk);
        n0 = m_acc[0];
        n1 = m_acc[1];
        if (load) begin
            n0 = longint'(in) <<< kk;
            n1 = n0;
        end else if (!hold) begin
            if (oe >= 1) n0 = m_acc[0] + longint'(in) - y0;
            if (oe >= 2) n1 = m_acc[1] + y0 - y1;
        end
        if (tau <= 6'd28 && oe >= 1) m_out = (oe == 1) ? 14'(y0) : 14'(y1);
        else m_out = in;
        m_acc[0] = n0;
        m_acc[1] = n1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; hold = 1'b0; load = 1'b0; clr_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_acc[0] = 0; m_acc[1] = 0; m_out = '0;
    endtask

    task automatic test_reset();
        tau = 6'd0; order = 3'd1; in = 14'sd0;
        do_reset();
        total++; if (out !== 14'sd0) begin bad++; $display("FAIL reset_out got=%0d want=0", out); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        total++; if (settled !== 1'b0) begin bad++; $display("FAIL reset_settled got=%b want=0", settled); end
        total++; if (ovf2 !== 1'b0) begin bad++; $display("FAIL reset_ovf2 got=%b want=0", ovf2); end
    endtask

    task automatic test_step_order1();
        in = 14'sd1000;
        for (int n = 1; n <= 700; n++) begin
            tick();
            if (n <= 200) o1[n] = int'(out);
            total++; if (out !== m_out) begin bad++; $display("FAIL step1_model n=%0d got=%0d want=%0d", n, out, m_out); end
            if (n == 1) begin
                total++; if (out !== 14'sd0) begin bad++; $display("FAIL step1_first got=%0d want=0", out); end
            end
            if (n == 65) begin
                // 1000*(1-(63/64)^64) is about 635
                total++; if (out < 14'sd633 || out > 14'sd637) begin bad++; $display("FAIL step1_tau got=%0d want=633..637", out); end
            end
            if (n == 640) begin
                total++; if (out < 14'sd998) begin bad++; $display("FAIL step1_final got=%0d want>=998", out); end
            end
            if (n == 511) begin
                total++; if (settled !== 1'b0) begin bad++; $display("FAIL step1_settle_early got=%b want=0", settled); end
            end
            if (n == 512) begin
                total++; if (settled !== 1'b1) begin bad++; $display("FAIL step1_settle got=%b want=1", settled); end
            end
        end
    endtask

    task automatic test_order2();
        tau = 6'd0; order = 3'd1; in = 14'sd0;
        do_reset();
        order = 3'd2; in = 14'sd1000;
        for (int n = 1; n <= 1100; n++) begin
            tick();
            total++; if (out !== m_out) begin bad++; $display("FAIL order2_model n=%0d got=%0d want=%0d", n, out, m_out); end
            total++; if (out > 14'sd1000) begin bad++; $display("FAIL order2_overshoot n=%0d got=%0d want<=1000", n, out); end
            if (n <= 200) begin
                total++; if (int'(out) > o1[n]) begin bad++; $display("FAIL order2_lag n=%0d got=%0d want<=%0d", n, out, o1[n]); end
            end
            if (n == 65) begin
                total++; if (int'(out) >= o1[65]) begin bad++; $display("FAIL order2_lag65 got=%0d want<%0d", out, o1[65]); end
            end
            if (n == 1024) begin
                total++; if (settled !== 1'b0) begin bad++; $display("FAIL order2_settle_early got=%b want=0", settled); end
            end
            if (n == 1025) begin
                total++; if (settled !== 1'b1) begin bad++; $display("FAIL order2_settle got=%b want=1", settled); end
            end
        end
    endtask

    task automatic test_load_hold();
        tau = 6'd10; in = -14'sd5000; load = 1'b1;
        tick();
        load = 1'b0; hold = 1'b1; in = 14'sd0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            total++; if (out !== -14'sd5000) begin bad++; $display("FAIL load_hold n=%0d got=%0d want=-5000", n, out); end
            total++; if (out !== m_out) begin bad++; $display("FAIL load_model n=%0d got=%0d want=%0d", n, out, m_out); end
        end
        total++; if (settled !== 1'b0) begin bad++; $display("FAIL load_settled got=%b want=0", settled); end
        hold = 1'b0;
    endtask

    task automatic test_hold_settle();
        tau = 6'd0; order = 3'd1; in = 14'sd0;
        do_reset();
        for (int n = 1; n <= 700; n++) begin
            hold = (n > 100 && n <= 200);
            tick();
            if (n == 200) begin
                total++; if (settled !== 1'b0) begin bad++; $display("FAIL hold_settle_mid got=%b want=0", settled); end
            end
            if (n == 611) begin
                total++; if (settled !== 1'b0) begin bad++; $display("FAIL hold_settle_early got=%b want=0", settled); end
            end
            if (n == 612) begin
                total++; if (settled !== 1'b1) begin bad++; $display("FAIL hold_settle got=%b want=1", settled); end
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_bypass();
        tau = 6'd40; order = 3'd1; in = 14'sd0;
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            in = 14'(100 * n);
            tick();
            total++; if (out !== 14'(100 * n)) begin bad++; $display("FAIL bypass_out n=%0d got=%0d want=%0d", n, out, 100 * n); end
            total++; if (settled !== 1'b1) begin bad++; $display("FAIL bypass_settled n=%0d got=%b want=1", n, settled); end
        end
        tau = 6'd2; in = 14'sd500;
        for (int n = 1; n <= 2100; n++) begin
            tick();
            total++; if (out !== m_out) begin bad++; $display("FAIL resume_model n=%0d got=%0d want=%0d", n, out, m_out); end
            if (n == 1 || n == 2048) begin
                total++; if (settled !== 1'b0) begin bad++; $display("FAIL resume_unsettled n=%0d got=%b want=0", n, settled); end
            end
            if (n == 2049) begin
                total++; if (settled !== 1'b1) begin bad++; $display("FAIL resume_settle got=%b want=1", settled); end
            end
        end
    endtask

    task automatic test_reset_mid();
        tau = 6'd0; order = 3'd1; in = 14'sd0;
        do_reset();
        in = 14'sd1000;
        for (int n = 1; n <= 600; n++) tick();
        total++; if (settled !== 1'b1) begin bad++; $display("FAIL mid_presettle got=%b want=1", settled); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (out !== 14'sd0) begin bad++; $display("FAIL mid_rst_out got=%0d want=0", out); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL mid_rst_ovf got=%b want=0", ovf); end
        total++; if (settled !== 1'b0) begin bad++; $display("FAIL mid_rst_settled got=%b want=0", settled); end
        rst = 1'b0;
        m_acc[0] = 0; m_acc[1] = 0; m_out = '0;
        order = 3'd0;
        for (int n = 1; n <= 10; n++) begin
            in = 14'(-300 * n);
            tick();
            total++; if (out !== 14'(-300 * n)) begin bad++; $display("FAIL order0_out n=%0d got=%0d want=%0d", n, out, -300 * n); end
            total++; if (settled !== 1'b1) begin bad++; $display("FAIL order0_settled n=%0d got=%b want=1", n, settled); end
        end
    endtask

    task automatic test_saturation();
        tau = 6'd0; order = 3'd1; in = 14'sd0;
        in2 = 14'sd0; clr2 = 1'b0;
        do_reset();
        in2 = 14'sd8191;
        for (int n = 1; n <= 65; n++) begin
            tick();
            if (n == 1) begin
                total++; if (out2 !== 14'sd8191) begin bad++; $display("FAIL sat_bypass got=%0d want=8191", out2); end
            end
            if (n == 1 || n == 30) begin
                total++; if (ovf2 !== 1'b0) begin bad++; $display("FAIL sat_early n=%0d got=%b want=0", n, ovf2); end
            end
            if (n == 60 || n == 65) begin
                total++; if (ovf2 !== 1'b1) begin bad++; $display("FAIL sat_set n=%0d got=%b want=1", n, ovf2); end
            end
        end
        clr2 = 1'b1;
        tick();
        total++; if (ovf2 !== 1'b1) begin bad++; $display("FAIL sat_clr_race got=%b want=1", ovf2); end
        in2 = 14'sd0;
        tick();
        total++; if (ovf2 !== 1'b0) begin bad++; $display("FAIL sat_clr got=%b want=0", ovf2); end
        clr2 = 1'b0;
        tick();
        total++; if (ovf2 !== 1'b0) begin bad++; $display("FAIL sat_stay_clear got=%b want=0", ovf2); end
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; load = 1'b0; clr_ovf = 1'b0;
        tau = 6'd0; order = 3'd1; in = 14'sd0;
        tau2 = 6'd0; order2 = 3'd1; hold2 = 1'b0; load2 = 1'b0; clr2 = 1'b0; in2 = 14'sd0;
        m_acc[0] = 0; m_acc[1] = 0; m_out = '0;
        test_reset();
        test_step_order1();
        test_order2();
        test_load_hold();
        test_hold_settle();
        test_bypass();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
